// File: rtl/pump_pkg.sv
// Shared types and limits for the pump soft-start driver.
package pump_pkg;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RAMP = 2'd1,
    CH_HOLD = 2'd2,
    CH_TRIP = 2'd3
  } ch_state_e;

  localparam int NUM_CH_MAX = 8;

endpackage

// File: rtl/pump_ramp_channel.sv
// One pump channel: target register, slew-limited applied duty, state machine and PWM compare.
module pump_ramp_channel
  import pump_pkg::*;
#(
  parameter int DUTY_W    = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              load,
  input  logic [DUTY_W-1:0] target_in,
  input  logic              trip,
  input  logic              trip_release,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_actual,
  output logic              at_target
);

  localparam int              SW   = DUTY_W + 1;
  localparam logic [SW-1:0]   STEP = SW'(RAMP_STEP);

  ch_state_e         state_r, state_s;
  logic [DUTY_W-1:0] target_r, target_s;
  logic [DUTY_W-1:0] actual_r, actual_s;
  logic [DUTY_W-1:0] ramped_s;
  logic [SW-1:0]     diff_s;
  logic              at_target_r, at_target_s;
  logic              pwm_r;

  // Next duty one slew step toward the target; a gap smaller than the step lands exactly.
  always_comb begin
    diff_s   = '0;
    ramped_s = actual_r;
    if (target_r > actual_r) begin
      diff_s   = {1'b0, target_r - actual_r};
      ramped_s = (diff_s < STEP) ? target_r : actual_r + STEP[DUTY_W-1:0];
    end else if (target_r < actual_r) begin
      diff_s   = {1'b0, actual_r - target_r};
      ramped_s = (diff_s < STEP) ? target_r : actual_r - STEP[DUTY_W-1:0];
    end else begin
      diff_s   = '0;
      ramped_s = actual_r;
    end
  end

  // Channel state machine, duty update and at-target status.
  always_comb begin
    state_s  = state_r;
    actual_s = actual_r;
    target_s = load ? target_in : target_r;
    if (trip) begin
      state_s  = CH_TRIP;
      actual_s = '0;
    end else begin
      case (state_r)
        CH_OFF: begin
          if (target_r != actual_r) state_s = CH_RAMP;
          else                      state_s = CH_OFF;
        end
        CH_RAMP, CH_HOLD: begin
          if ((target_r == '0) && (actual_r == '0)) state_s = CH_OFF;
          else if (target_r == actual_r)            state_s = CH_HOLD;
          else                                      state_s = CH_RAMP;
        end
        CH_TRIP: begin
          if (trip_release) state_s = CH_OFF;
          else              state_s = CH_TRIP;
        end
        default: state_s = CH_OFF;
      endcase
      // Duty only moves on a period boundary so a PWM period is never cut short.
      if (state_r == CH_TRIP)       actual_s = '0;
      else if (tick && boundary)    actual_s = ramped_s;
      else                          actual_s = actual_r;
    end
    at_target_s = (actual_s == target_s) && (state_s != CH_TRIP);
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= CH_OFF;
      target_r    <= '0;
      actual_r    <= '0;
      at_target_r <= 1'b1;
      pwm_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      target_r    <= target_s;
      actual_r    <= actual_s;
      at_target_r <= at_target_s;
      pwm_r       <= (cnt < actual_r);
    end
  end

  assign pwm_out     = pwm_r;
  assign duty_actual = actual_r;
  assign at_target   = at_target_r;

endmodule

// File: rtl/pump_ramp_array.sv
// N-channel soft-start pump driver: shared PWM timebase and dry-run latch feeding per-channel ramps.
module pump_ramp_array
  import pump_pkg::*;
#(
  parameter int                NUM_CH    = 2,
  parameter int                DUTY_W    = 8,
  parameter int                PWM_DIV   = 1,
  parameter int                RAMP_STEP = 4,
  parameter logic [NUM_CH-1:0] DRY_MASK  = {NUM_CH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DUTY_W-1:0] duty_target,
  input  logic                     target_load,
  input  logic                     is_empty,
  input  logic                     fault_clear,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*DUTY_W-1:0] duty_actual,
  output logic [NUM_CH-1:0]        at_target,
  output logic                     dry_fault
);

  localparam int                DIV_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PWM_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX  = DUTY_W'((2 ** DUTY_W) - 2);

  if ((NUM_CH < 1) || (NUM_CH > NUM_CH_MAX)) begin : g_bad_num_ch
    $error("pump_ramp_array: NUM_CH out of range");
  end

  logic [DIV_W-1:0]  div_r;
  logic [DUTY_W-1:0] cnt_r;
  logic              tick_s;
  logic              boundary_s;
  logic              release_s;
  logic              dry_fault_r;

  // Timebase decode and fault release qualifier.
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    boundary_s = tick_s && (cnt_r == CNT_MAX);
    release_s  = fault_clear && !is_empty;
  end

  // Tick prescaler and PWM period counter; the period is 2**DUTY_W-1 ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= '0;
      cnt_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
      cnt_r <= (cnt_r == CNT_MAX) ? '0 : cnt_r + DUTY_W'(1);
    end else begin
      div_r <= div_r + DIV_W'(1);
      cnt_r <= cnt_r;
    end
  end

  // Dry-run latch: only a clear while the sensor reads wet releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      dry_fault_r <= 1'b0;
    end else if (is_empty && (|DRY_MASK)) begin
      dry_fault_r <= 1'b1;
    end else if (release_s) begin
      dry_fault_r <= 1'b0;
    end else begin
      dry_fault_r <= dry_fault_r;
    end
  end

  assign dry_fault = dry_fault_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pump_ramp_channel #(
      .DUTY_W    (DUTY_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick_s),
      .boundary     (boundary_s),
      .cnt          (cnt_r),
      .load         (target_load),
      .target_in    (duty_target[i*DUTY_W +: DUTY_W]),
      .trip         (is_empty && DRY_MASK[i]),
      .trip_release (release_s),
      .pwm_out      (pwm_out[i]),
      .duty_actual  (duty_actual[i*DUTY_W +: DUTY_W]),
      .at_target    (at_target[i])
    );
  end

endmodule

// File: tb/tb_pump_ramp_array.sv
// Self-checking bench: default-parameter DUT against a behavioural model, plus mask and divider variants.
module tb_pump_ramp_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default configuration: 2 ch, 8-bit, DIV 1, STEP 4, both channels masked.
  logic        reset = 1'b1, target_load = 1'b0, is_empty = 1'b0, fault_clear = 1'b0;
  logic [15:0] duty_target = 16'h0000;
  logic [1:0]  pwm_out, at_target;
  logic [15:0] duty_actual;
  logic        dry_fault;

  // Dry mask 2'b10 variant.
  logic        b_reset = 1'b1, b_load = 1'b0, b_empty = 1'b0, b_clr = 1'b0;
  logic [15:0] b_dt = 16'h0000;
  logic [1:0]  b_pwm, b_at;
  logic [15:0] b_duty;
  logic        b_fault;

  // PWM_DIV 3, RAMP_STEP 255 variant.
  logic        c_reset = 1'b1, c_load = 1'b0, c_empty = 1'b0, c_clr = 1'b0;
  logic [15:0] c_dt = 16'h0000;
  logic [1:0]  c_pwm, c_at;
  logic [15:0] c_duty;
  logic        c_fault;

  pump_ramp_array dut (
    .clk(clk), .reset(reset), .duty_target(duty_target), .target_load(target_load),
    .is_empty(is_empty), .fault_clear(fault_clear), .pwm_out(pwm_out),
    .duty_actual(duty_actual), .at_target(at_target), .dry_fault(dry_fault)
  );

  pump_ramp_array #(.DRY_MASK(2'b10)) dut_b (
    .clk(clk), .reset(b_reset), .duty_target(b_dt), .target_load(b_load),
    .is_empty(b_empty), .fault_clear(b_clr), .pwm_out(b_pwm),
    .duty_actual(b_duty), .at_target(b_at), .dry_fault(b_fault)
  );

  pump_ramp_array #(.PWM_DIV(3), .RAMP_STEP(255)) dut_c (
    .clk(clk), .reset(c_reset), .duty_target(c_dt), .target_load(c_load),
    .is_empty(c_empty), .fault_clear(c_clr), .pwm_out(c_pwm),
    .duty_actual(c_duty), .at_target(c_at), .dry_fault(c_fault)
  );

  logic [20:0] obs_a;
  assign obs_a = {pwm_out, duty_actual, at_target, dry_fault};

  // Behavioural model of the default DUT.
  int m_target[2];
  int m_actual[2];
  bit m_trip[2];
  bit m_pwm[2];
  bit m_at[2];
  bit m_fault;
  int m_clk;

  function automatic int approach(int a, int t);
    if (t > a) return a + (((t - a) < 4) ? (t - a) : 4);
    if (t < a) return a - (((a - t) < 4) ? (a - t) : 4);
    return a;
  endfunction

  task automatic model_step();
    int cnt_b;
    bit bnd;
    int nt[2];
    nt[0] = int'(duty_target[7:0]);
    nt[1] = int'(duty_target[15:8]);
    if (reset) begin
      m_clk   = 0;
      m_fault = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_target[i] = 0; m_actual[i] = 0; m_trip[i] = 1'b0; m_pwm[i] = 1'b0; m_at[i] = 1'b1;
      end
    end else begin
      cnt_b = m_clk % 255;
      bnd   = (cnt_b == 254);
      for (int i = 0; i < 2; i++) begin
        m_pwm[i] = (cnt_b < m_actual[i]);
        if (is_empty) begin
          m_trip[i] = 1'b1; m_actual[i] = 0;
        end else if (m_trip[i]) begin
          m_actual[i] = 0;
          if (fault_clear) m_trip[i] = 1'b0;
        end else if (bnd) begin
          m_actual[i] = approach(m_actual[i], m_target[i]);
        end
        if (target_load) m_target[i] = nt[i];
        m_at[i] = !m_trip[i] && (m_actual[i] == m_target[i]);
      end
      if (is_empty) m_fault = 1'b1;
      else if (fault_clear) m_fault = 1'b0;
      m_clk++;
    end
  endtask

  function automatic logic [20:0] exp_a();
    return {m_pwm[1], m_pwm[0], 8'(m_actual[1]), 8'(m_actual[0]), m_at[1], m_at[0], m_fault};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if ({pwm_out, duty_actual, at_target, dry_fault} !== {2'b00, 16'h0000, 2'b11, 1'b0}) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs_a, {2'b00, 16'h0000, 2'b11, 1'b0});
    end
    reset = 1'b0;
    for (int n = 0; n < 765; n++) begin
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL idle_after_reset t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
  endtask

  task automatic test_ramp_up();
    duty_target = {8'd255, 8'd100}; target_load = 1'b1;
    cyc();
    target_load = 1'b0;
    for (int n = 0; n < 70 * 255; n++) begin
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL ramp_up t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    checks++;
    if ({duty_actual, at_target} !== {16'hFF64, 2'b11}) begin
      errors++; $display("FAIL ramp_up_final got=%h exp=%h", {duty_actual, at_target}, {16'hFF64, 2'b11});
    end
  endtask

  task automatic test_ramp_down();
    duty_target = {8'd255, 8'd2}; target_load = 1'b1;
    cyc();
    target_load = 1'b0;
    for (int n = 0; n < 26 * 255; n++) begin
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL ramp_down t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    checks++;
    if (duty_actual[7:0] !== 8'd2) begin errors++; $display("FAIL ramp_down_partial got=%0d exp=2", duty_actual[7:0]); end
    duty_target = {8'd255, 8'd0}; target_load = 1'b1;
    cyc();
    target_load = 1'b0;
    for (int n = 0; n < 2 * 255; n++) begin
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL ramp_to_zero t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    checks++;
    if ({duty_actual, at_target} !== {16'hFF00, 2'b11}) begin
      errors++; $display("FAIL ramp_to_zero_final got=%h exp=%h", {duty_actual, at_target}, {16'hFF00, 2'b11});
    end
  endtask

  task automatic test_dry_trip();
    duty_target = {8'd200, 8'd100}; target_load = 1'b1;
    cyc();
    target_load = 1'b0;
    for (int n = 0; n < 27 * 255 + 100; n++) begin
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL hold_before_trip t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    is_empty = 1'b1;
    cyc();
    checks++;
    if ({duty_actual, at_target, dry_fault} !== {16'h0000, 2'b00, 1'b1}) begin
      errors++; $display("FAIL trip_edge got=%h exp=%h", {duty_actual, at_target, dry_fault}, {16'h0000, 2'b00, 1'b1});
    end
    cyc();
    checks++;
    if (pwm_out !== 2'b00) begin errors++; $display("FAIL trip_pwm got=%b exp=00", pwm_out); end
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n == 20) is_empty = 1'b0;
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL trip_hold t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    checks++;
    if (dry_fault !== 1'b1) begin errors++; $display("FAIL fault_latched got=%b exp=1", dry_fault); end
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    for (int n = 0; n < 52 * 255; n++) begin
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL re_ramp t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    checks++;
    if ({duty_actual, at_target, dry_fault} !== {16'hC864, 2'b11, 1'b0}) begin
      errors++; $display("FAIL re_ramp_final got=%h exp=%h", {duty_actual, at_target, dry_fault}, {16'hC864, 2'b11, 1'b0});
    end
  endtask

  task automatic test_mask();
    b_reset = 1'b0; b_dt = {8'd60, 8'd60}; b_load = 1'b1;
    cyc();
    b_load = 1'b0;
    for (int n = 0; n < 16 * 255 + 37; n++) cyc();
    checks++;
    if ({b_duty, b_at, b_fault} !== {16'h3C3C, 2'b11, 1'b0}) begin
      errors++; $display("FAIL mask_hold got=%h exp=%h", {b_duty, b_at, b_fault}, {16'h3C3C, 2'b11, 1'b0});
    end
    b_empty = 1'b1;
    cyc();
    checks++;
    if ({b_duty, b_at, b_fault} !== {16'h003C, 2'b01, 1'b1}) begin
      errors++; $display("FAIL mask_trip got=%h exp=%h", {b_duty, b_at, b_fault}, {16'h003C, 2'b01, 1'b1});
    end
    for (int n = 0; n < 2 * 255; n++) cyc();
    checks++;
    if ({b_duty, b_pwm[1], b_fault} !== {16'h003C, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mask_unmasked_runs got=%h exp=%h", {b_duty, b_pwm[1], b_fault}, {16'h003C, 1'b0, 1'b1});
    end
    b_empty = 1'b0; b_clr = 1'b1;
    cyc();
    b_clr = 1'b0;
    checks++;
    if (b_fault !== 1'b0) begin errors++; $display("FAIL mask_clear got=%b exp=0", b_fault); end
    for (int n = 0; n < 16 * 255; n++) cyc();
    checks++;
    if ({b_duty, b_at} !== {16'h3C3C, 2'b11}) begin
      errors++; $display("FAIL mask_reramp got=%h exp=%h", {b_duty, b_at}, {16'h3C3C, 2'b11});
    end
  endtask

  task automatic test_div3();
    int hi0 = 0;
    int hi1 = 0;
    c_reset = 1'b1;
    cyc();
    c_reset = 1'b0; c_dt = {8'd0, 8'd128}; c_load = 1'b1;
    cyc();
    c_load = 1'b0;
    for (int n = 0; n < 763; n++) cyc();
    checks++;
    if ({c_duty, c_at} !== {16'h0000, 2'b10}) begin
      errors++; $display("FAIL div3_before_boundary got=%h exp=%h", {c_duty, c_at}, {16'h0000, 2'b10});
    end
    cyc();
    checks++;
    if ({c_duty, c_at} !== {16'h0080, 2'b11}) begin
      errors++; $display("FAIL div3_jump got=%h exp=%h", {c_duty, c_at}, {16'h0080, 2'b11});
    end
    for (int n = 0; n < 765; n++) begin
      cyc();
      hi0 += int'(c_pwm[0]);
      hi1 += int'(c_pwm[1]);
    end
    checks++;
    if ((hi0 !== 384) || (hi1 !== 0)) begin errors++; $display("FAIL div3_pwm_high got=%0d/%0d exp=384/0", hi0, hi1); end
    for (int n = 0; n < 100; n++) cyc();
    checks++;
    if (c_duty !== 16'h0080) begin errors++; $display("FAIL div3_pre_reset got=%h exp=0080", c_duty); end
    c_reset = 1'b1;
    cyc();
    c_reset = 1'b0;
    checks++;
    if ({c_pwm, c_duty, c_at, c_fault} !== {2'b00, 16'h0000, 2'b11, 1'b0}) begin
      errors++; $display("FAIL div3_reset got=%h exp=%h", {c_pwm, c_duty, c_at, c_fault}, {2'b00, 16'h0000, 2'b11, 1'b0});
    end
  endtask

  task automatic test_random();
    int dry_left = 0;
    int pick;
    for (int n = 0; n < 15000; n++) begin
      reset       = ($urandom_range(0, 4999) == 0);
      target_load = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        pick = int'($urandom_range(0, 3));
        duty_target[i*8 +: 8] = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom);
      end
      if (dry_left > 0) begin
        is_empty = 1'b1; dry_left--;
      end else begin
        is_empty = 1'b0;
        if ($urandom_range(0, 1199) == 0) dry_left = int'($urandom_range(1, 40));
      end
      fault_clear = ($urandom_range(0, 99) == 0);
      cyc();
      checks++;
      if (obs_a !== exp_a()) begin errors++; $display("FAIL random t=%0t got=%h exp=%h", $time, obs_a, exp_a()); end
    end
    reset = 1'b0; target_load = 1'b0; is_empty = 1'b0; fault_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_dry_trip();
    test_mask();
    test_div3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
